sonar_range_unit: RTL

Ultrasonic (HC-SR04) front end that sits directly upstream of the game controller's position check. On a one-cycle `medir` request it:
- issues a 10 us trigger;
- times the echo pulse;
- converts the pulse width to centimetres (3-digit BCD) with half-up rounding;
- returns the result with a one-cycle `pronto` strobe, or a `timeout` strobe if no valid echo arrives.

---
 rtl/sonar_pkg.sv | 48 ++++
 rtl/sonar_range_unit_bcd_counter3.sv | 38 +++
 rtl/sonar_range_unit.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/sonar_pkg.sv
// Shared types and default timing constants for the HC-SR04 sonar range unit.
// Timing defaults assume a 50 MHz system clock.
package sonar_pkg;

   localparam int CLK_HZ        = 50_000_000;
   localparam int TRIGGER_CYC   = 500;
   localparam int CYCLES_PER_CM = 2941;
   localparam int TIMEOUT_CYC   = 1_500_000;

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_TRIG      = 4'd1,
      S_WAIT_ECHO = 4'd2,
      S_MEASURE   = 4'd3,
      S_ROUND     = 4'd4,
      S_DONE      = 4'd5,
      S_TOUT      = 4'd6
   } state_e;

   typedef logic [3:0] bcd_digit_t;

   typedef struct packed {
      bcd_digit_t hund;
      bcd_digit_t tens;
      bcd_digit_t units;
   } bcd3_t;

   // Decimal increment of a 3-digit BCD value that sticks at 999.
   function automatic bcd3_t bcd3_inc_sat(input bcd3_t v);
      bcd3_t r;
      r = v;
      if (v == 12'h999) begin
         r = v;
      end else if (v.units != 4'd9) begin
         r.units = v.units + 4'd1;
      end else begin
         r.units = 4'd0;
         if (v.tens != 4'd9) begin
            r.tens = v.tens + 4'd1;
         end else begin
            r.tens = 4'd0;
            r.hund = v.hund + 4'd1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/sonar_range_unit_bcd_counter3.sv
// Three-digit BCD counter (bcd_counter3): synchronous clear, increment enable,
// saturation at 999. Also exposes its next value for same-edge consumers.
module bcd_counter3
   import sonar_pkg::*;
(
   input  logic  clock,
   input  logic  reset,
   input  logic  clr,
   input  logic  inc,
   output bcd3_t count,
   output bcd3_t count_nxt
);

   bcd3_t count_q, count_d;

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc) begin
         count_d = bcd3_inc_sat(count_q);
      end
   end

   // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count     = count_q;
   assign count_nxt = count_d;

endmodule

// File: rtl/sonar_range_unit.sv
// HC-SR04 front end: trigger pulse, echo timing, centimetre conversion to BCD.
// Define SONAR_ROUND_EN for half-up rounding; otherwise the result is truncated.
module sonar_range_unit
   import sonar_pkg::*;
#(
   parameter int TRIGGER_CYC   = sonar_pkg::TRIGGER_CYC,
   parameter int CYCLES_PER_CM = sonar_pkg::CYCLES_PER_CM,
   parameter int TIMEOUT_CYC   = sonar_pkg::TIMEOUT_CYC
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        medir,
   input  logic        echo,
   output logic        trigger,
   output logic [11:0] medida,
   output logic        pronto,
   output logic        timeout,
   output logic        ocupado,
   output logic [3:0]  db_estado
);

   localparam int TMR_MAX = (TIMEOUT_CYC > TRIGGER_CYC) ? TIMEOUT_CYC : TRIGGER_CYC;
   localparam int TMR_W   = $clog2(TMR_MAX);
   localparam int DIV_W   = $clog2(CYCLES_PER_CM);

   localparam logic [TMR_W-1:0] TRIG_LAST = TMR_W'(TRIGGER_CYC - 1);
   localparam logic [TMR_W-1:0] TOUT_LAST = TMR_W'(TIMEOUT_CYC - 1);
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CYCLES_PER_CM - 1);
`ifdef SONAR_ROUND_EN
   localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(CYCLES_PER_CM / 2);
`endif

   state_e           state_q, state_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic [DIV_W-1:0] cm_div_q, cm_div_d;
   bcd3_t            medida_q, medida_d;
   logic             echo_s1_q, echo_s2_q;
   logic             trigger_q, trigger_d;
   logic             pronto_q, pronto_d;
   logic             timeout_q, timeout_d;
   logic             ocupado_q, ocupado_d;

   logic  acc_clr, acc_inc, round_up;
   bcd3_t acc, acc_nxt;

   bcd_counter3 u_acc (
      .clock     (clock),
      .reset     (reset),
      .clr       (acc_clr),
      .inc       (acc_inc),
      .count     (acc),
      .count_nxt (acc_nxt)
   );

   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      cm_div_d = cm_div_q;
      medida_d = medida_q;
      acc_clr  = 1'b0;
      acc_inc  = 1'b0;
      round_up = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (medir) begin
               state_d  = S_TRIG;
               timer_d  = '0;
               cm_div_d = '0;
               acc_clr  = 1'b1;
            end
         end
         S_TRIG: begin
            if (timer_q == TRIG_LAST) begin
               state_d = S_WAIT_ECHO;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         S_WAIT_ECHO: begin
            timer_d = timer_q + TMR_W'(1);
            if (timer_q == TOUT_LAST) begin
               state_d = S_TOUT;
            end else if (echo_s2_q) begin
               state_d = S_MEASURE;
            end
         end
         S_MEASURE: begin
            // The timeout budget spans the whole wait + echo window, so the timer keeps running.
            timer_d = timer_q + TMR_W'(1);
            if (cm_div_q == DIV_LAST) begin
               cm_div_d = '0;
               acc_inc  = 1'b1;
            end else begin
               cm_div_d = cm_div_q + DIV_W'(1);
            end
            if (timer_q == TOUT_LAST) begin
               state_d = S_TOUT;
            end else if (!echo_s2_q) begin
               state_d = S_ROUND;
            end
         end
         S_ROUND: begin
`ifdef SONAR_ROUND_EN
            round_up = (cm_div_q >= DIV_HALF);
`endif
            acc_inc  = round_up;
            // Load the final value on entry to DONE so medida is valid while pronto is high.
            medida_d = acc_nxt;
            state_d  = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         S_TOUT: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      trigger_d = (state_d == S_TRIG);
      pronto_d  = (state_d == S_DONE);
      timeout_d = (state_d == S_TOUT);
      ocupado_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= S_IDLE;
         timer_q   <= '0;
         cm_div_q  <= '0;
         medida_q  <= '0;
         echo_s1_q <= 1'b0;
         echo_s2_q <= 1'b0;
         trigger_q <= 1'b0;
         pronto_q  <= 1'b0;
         timeout_q <= 1'b0;
         ocupado_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         cm_div_q  <= cm_div_d;
         medida_q  <= medida_d;
         echo_s1_q <= echo;
         echo_s2_q <= echo_s1_q;
         trigger_q <= trigger_d;
         pronto_q  <= pronto_d;
         timeout_q <= timeout_d;
         ocupado_q <= ocupado_d;
      end
   end

   assign trigger   = trigger_q;
   assign medida    = medida_q;
   assign pronto    = pronto_q;
   assign timeout   = timeout_q;
   assign ocupado   = ocupado_q;
   assign db_estado = state_q;

endmodule
